std_cache_way_arbiter: RTL and testbench

//  Parametrised N-port arbiter plus 1-stage tag compare for the set-associative L1 data-cache arrays.

---
 rtl/std_cache_way_arbiter_if.sv | 45 ++++
 rtl/std_cache_way_arbiter.sv | 161 ++++++++++++++++
 tb/tb_std_cache_way_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/std_cache_way_arbiter_if.sv
// Requester, response and array-side signals of the cache way arbiter.
// master = requesters plus the arrays' read-back; slave = the arbiter.
interface std_cache_way_arbiter_if #(
  parameter int unsigned NR_PORTS    = 5,
  parameter int unsigned SET_ASSOC   = 8,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned TAG_WIDTH   = 44,
  parameter int unsigned LINE_WIDTH  = 128
);
  localparam int unsigned WD_WIDTH = TAG_WIDTH + LINE_WIDTH;
  localparam int unsigned BE_WIDTH = WD_WIDTH / 8;

  logic [NR_PORTS-1:0][SET_ASSOC-1:0]   req;
  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0] addr;
  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]   tag;
  logic [NR_PORTS-1:0]                  we;
  logic [NR_PORTS-1:0][WD_WIDTH-1:0]    wdata;
  logic [NR_PORTS-1:0][BE_WIDTH-1:0]    be;
  logic [NR_PORTS-1:0]                  gnt;
  logic [NR_PORTS-1:0]                  rvalid;
  logic [SET_ASSOC-1:0]                 hit_way;
  logic [LINE_WIDTH-1:0]                hit_data;
  logic                                 multi_hit;

  logic [SET_ASSOC-1:0]                 sram_req;
  logic [INDEX_WIDTH-1:0]               sram_addr;
  logic                                 sram_we;
  logic [WD_WIDTH-1:0]                  sram_wdata;
  logic [BE_WIDTH-1:0]                  sram_be;
  logic [SET_ASSOC-1:0][TAG_WIDTH-1:0]  rtag;
  logic [SET_ASSOC-1:0][LINE_WIDTH-1:0] rdata;
  logic [SET_ASSOC-1:0]                 valid;

  modport master (
    output req, addr, tag, we, wdata, be, rtag, rdata, valid,
    input  gnt, rvalid, hit_way, hit_data, multi_hit,
           sram_req, sram_addr, sram_we, sram_wdata, sram_be
  );

  modport slave (
    input  req, addr, tag, we, wdata, be, rtag, rdata, valid,
    output gnt, rvalid, hit_way, hit_data, multi_hit,
           sram_req, sram_addr, sram_we, sram_wdata, sram_be
  );
endinterface

// File: rtl/std_cache_way_arbiter.sv
// N-port L1 data-cache array arbiter with starvation guard and a one-stage tag compare.
// Define DCACHE_ARB_PERF_EN to build the grant / conflict / multi-hit perf counters.
module std_cache_way_arbiter #(
  parameter int unsigned NR_PORTS     = 5,
  parameter int unsigned SET_ASSOC    = 8,
  parameter int unsigned INDEX_WIDTH  = 12,
  parameter int unsigned TAG_WIDTH    = 44,
  parameter int unsigned LINE_WIDTH   = 128,
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  std_cache_way_arbiter_if.slave bus,
  output logic [31:0]            perf_gnt_o,
  output logic [31:0]            perf_conflict_o,
  output logic [31:0]            perf_multihit_o
);
  localparam int unsigned PW    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam logic [3:0]  LIMIT = 4'(STARVE_LIMIT);

  logic [NR_PORTS-1:0]  port_req;
  logic [NR_PORTS-1:0]  starve;
  logic [3:0]           wait_cnt_reg [NR_PORTS];
  logic [PW-1:0]        rr_ptr_reg;
  logic                 win_valid;
  logic [PW-1:0]        win_idx;
  logic                 rd_v_reg;
  logic [PW-1:0]        rd_id_reg;
  logic [TAG_WIDTH-1:0] tag_reg;
  logic [SET_ASSOC-1:0] hit;
  logic [SET_ASSOC-1:0] hit_low;

  for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
    assign port_req[gi]    = |bus.req[gi];
    assign starve[gi]      = port_req[gi] && (wait_cnt_reg[gi] == LIMIT);
    assign bus.gnt[gi]     = win_valid && (win_idx == PW'(gi));
    assign bus.rvalid[gi]  = rd_v_reg && (rd_id_reg == PW'(gi));

    // Waiting time since the current request was raised; reaching LIMIT forces a grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_cnt_reg[gi] <= '0;
      end else if (!port_req[gi] || bus.gnt[gi]) begin
        wait_cnt_reg[gi] <= '0;
      end else if (wait_cnt_reg[gi] != LIMIT) begin
        wait_cnt_reg[gi] <= wait_cnt_reg[gi] + 4'd1;
      end
    end
  end

  // Starving ports first, then the miss handler, then the selected policy over ports 1..N-1.
  always_comb begin
    int cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int p = NR_PORTS - 1; p >= 0; p--) begin
      if (starve[p]) begin
        win_valid = 1'b1;
        win_idx   = PW'(p);
      end
    end
    if (!win_valid && port_req[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
    if (!win_valid) begin
      for (int k = NR_PORTS - 2; k >= 0; k--) begin
        if (ARB_MODE == 0) cand = k + 1;
        else               cand = 1 + ((int'(rr_ptr_reg) - 1 + k) % (NR_PORTS - 1));
        if (port_req[cand]) begin
          win_valid = 1'b1;
          win_idx   = PW'(cand);
        end
      end
    end
    if (!rst_ni) begin
      win_valid = 1'b0;
      win_idx   = '0;
    end
  end

  always_comb begin
    bus.sram_req   = '0;
    bus.sram_addr  = '0;
    bus.sram_we    = 1'b0;
    bus.sram_wdata = '0;
    bus.sram_be    = '0;
    if (win_valid) begin
      bus.sram_req   = bus.req[win_idx];
      bus.sram_addr  = bus.addr[win_idx];
      bus.sram_we    = bus.we[win_idx];
      bus.sram_wdata = bus.wdata[win_idx];
      bus.sram_be    = bus.be[win_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg <= PW'(1);
      rd_v_reg   <= 1'b0;
      rd_id_reg  <= '0;
      tag_reg    <= '0;
    end else begin
      if (win_valid && (win_idx != '0)) begin
        rr_ptr_reg <= (win_idx == PW'(NR_PORTS - 1)) ? PW'(1) : win_idx + PW'(1);
      end
      rd_v_reg <= win_valid && !bus.we[win_idx];
      if (win_valid && !bus.we[win_idx]) begin
        rd_id_reg <= win_idx;
        tag_reg   <= bus.tag[win_idx];
      end
    end
  end

  for (genvar gi = 0; gi < SET_ASSOC; gi++) begin : g_way
    assign hit[gi] = rd_v_reg && bus.valid[gi] && (bus.rtag[gi] == tag_reg);
  end

  // Isolate the lowest hitting way; a second set bit means a multi-hit.
  assign hit_low       = hit & (~hit + SET_ASSOC'(1));
  assign bus.hit_way   = hit_low;
  assign bus.multi_hit = (hit & (hit - SET_ASSOC'(1))) != '0;

  always_comb begin
    bus.hit_data = '0;
    for (int w = 0; w < SET_ASSOC; w++) begin
      if (hit_low[w]) bus.hit_data = bus.rdata[w];
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_gnt_reg;
  logic [31:0] perf_conflict_reg;
  logic [31:0] perf_multihit_reg;
  logic        conflict;

  assign conflict = (port_req & (port_req - NR_PORTS'(1))) != '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_gnt_reg      <= '0;
      perf_conflict_reg <= '0;
      perf_multihit_reg <= '0;
    end else begin
      if (win_valid && (perf_gnt_reg != '1))       perf_gnt_reg      <= perf_gnt_reg + 32'd1;
      if (conflict && (perf_conflict_reg != '1))   perf_conflict_reg <= perf_conflict_reg + 32'd1;
      if (bus.multi_hit && (perf_multihit_reg != '1)) perf_multihit_reg <= perf_multihit_reg + 32'd1;
    end
  end

  assign perf_gnt_o      = perf_gnt_reg;
  assign perf_conflict_o = perf_conflict_reg;
  assign perf_multihit_o = perf_multihit_reg;
`else
  assign perf_gnt_o      = '0;
  assign perf_conflict_o = '0;
  assign perf_multihit_o = '0;
`endif
endmodule

// File: tb/tb_std_cache_way_arbiter.sv
// Bench for std_cache_way_arbiter: a fixed-priority and a round-robin instance see identical stimulus.
module tb_std_cache_way_arbiter;
  localparam int NP = 5, NW = 8, IW = 12, TW = 44, LW = 128;
  localparam int WW = TW + LW, BW = WW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_gnt = 0;
  bit mon_en = 1'b0;

  logic [31:0] pg_fp, pc_fp, pm_fp, pg_rr, pc_rr, pm_rr;
  logic [WW-1:0] wd_pat = {44'hABC_DEF0_1234, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
  logic [BW-1:0] be_pat = 21'h1A_5A5A;

  typedef struct {
    int            due;
    logic [NP-1:0] rvalid;
    logic [NW-1:0] way;
    logic [LW-1:0] data;
    logic          multi;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  std_cache_way_arbiter_if #(.NR_PORTS(NP), .SET_ASSOC(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus_fp ();
  std_cache_way_arbiter_if #(.NR_PORTS(NP), .SET_ASSOC(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .LINE_WIDTH(LW)) bus_rr ();

  assign bus_rr.req   = bus_fp.req;
  assign bus_rr.addr  = bus_fp.addr;
  assign bus_rr.tag   = bus_fp.tag;
  assign bus_rr.we    = bus_fp.we;
  assign bus_rr.wdata = bus_fp.wdata;
  assign bus_rr.be    = bus_fp.be;
  assign bus_rr.rtag  = bus_fp.rtag;
  assign bus_rr.rdata = bus_fp.rdata;
  assign bus_rr.valid = bus_fp.valid;

  std_cache_way_arbiter #(.NR_PORTS(NP), .SET_ASSOC(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
                          .LINE_WIDTH(LW), .ARB_MODE(0), .STARVE_LIMIT(15)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_fp),
    .perf_gnt_o(pg_fp), .perf_conflict_o(pc_fp), .perf_multihit_o(pm_fp)
  );

  std_cache_way_arbiter #(.NR_PORTS(NP), .SET_ASSOC(NW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
                          .LINE_WIDTH(LW), .ARB_MODE(1), .STARVE_LIMIT(15)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_rr),
    .perf_gnt_o(pg_rr), .perf_conflict_o(pc_rr), .perf_multihit_o(pm_rr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] line_of(input int w);
    logic [31:0] word;
    word = 32'hC0DE_0000 | 32'(w);
    return {4{word}};
  endfunction

  task automatic idle();
    bus_fp.req = '0; bus_fp.addr = '0; bus_fp.tag = '0;
    bus_fp.we = '0; bus_fp.wdata = '0; bus_fp.be = '0;
  endtask

  task automatic put(input int p, input logic [NW-1:0] ways, input logic [IW-1:0] a,
                     input logic [TW-1:0] t, input logic w, input logic [WW-1:0] d, input logic [BW-1:0] b);
    bus_fp.req[p] = ways; bus_fp.addr[p] = a; bus_fp.tag[p] = t;
    bus_fp.we[p] = w; bus_fp.wdata[p] = d; bus_fp.be[p] = b;
  endtask

  task automatic set_array(input logic [NW-1:0] v);
    for (int w = 0; w < NW; w++) begin
      bus_fp.rtag[w]  = 44'h100 + 44'(w);
      bus_fp.rdata[w] = line_of(w);
    end
    bus_fp.valid = v;
  endtask

  // Scoreboard: pops the response due this cycle, otherwise requires a quiet response port.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        total++; if (bus_fp.rvalid !== mon_e.rvalid || bus_rr.rvalid !== mon_e.rvalid) begin
          bad++; $display("FAIL rsp_rvalid fp=%b rr=%b want=%b", bus_fp.rvalid, bus_rr.rvalid, mon_e.rvalid); end
        total++; if (bus_fp.hit_way !== mon_e.way || bus_rr.hit_way !== mon_e.way) begin
          bad++; $display("FAIL rsp_hit_way fp=%h rr=%h want=%h", bus_fp.hit_way, bus_rr.hit_way, mon_e.way); end
        total++; if (bus_fp.hit_data !== mon_e.data || bus_rr.hit_data !== mon_e.data) begin
          bad++; $display("FAIL rsp_hit_data fp=%h rr=%h want=%h", bus_fp.hit_data, bus_rr.hit_data, mon_e.data); end
        total++; if (bus_fp.multi_hit !== mon_e.multi || bus_rr.multi_hit !== mon_e.multi) begin
          bad++; $display("FAIL rsp_multi fp=%b rr=%b want=%b", bus_fp.multi_hit, bus_rr.multi_hit, mon_e.multi); end
        $display("rsp cyc=%0d rvalid=%b hit_way=%h multi=%b", cyc, bus_fp.rvalid, bus_fp.hit_way, bus_fp.multi_hit);
      end else begin
        total++; if (bus_fp.rvalid !== '0 || bus_rr.rvalid !== '0 || bus_fp.hit_way !== '0 || bus_rr.hit_way !== '0) begin
          bad++; $display("FAIL rsp_quiet cyc=%0d fp=%b/%h rr=%b/%h want=0", cyc, bus_fp.rvalid, bus_fp.hit_way, bus_rr.rvalid, bus_rr.hit_way); end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    put(1, 8'h02, 12'h010, 44'h1, 1'b0, '0, '0);
    @(negedge clk); #1;
    total++; if (bus_fp.gnt !== '0 || bus_rr.gnt !== '0) begin
      bad++; $display("FAIL reset_gnt fp=%b rr=%b want=0", bus_fp.gnt, bus_rr.gnt); end
    total++; if (bus_fp.sram_req !== '0 || bus_fp.sram_we !== 1'b0 || bus_fp.sram_addr !== '0) begin
      bad++; $display("FAIL reset_sram req=%h we=%b addr=%h want=0", bus_fp.sram_req, bus_fp.sram_we, bus_fp.sram_addr); end
    total++; if (bus_fp.rvalid !== '0 || bus_fp.hit_way !== '0 || bus_fp.multi_hit !== 1'b0 || bus_fp.hit_data !== '0) begin
      bad++; $display("FAIL reset_rsp rvalid=%b hit_way=%h multi=%b want=0", bus_fp.rvalid, bus_fp.hit_way, bus_fp.multi_hit); end
    total++; if (pg_fp !== '0 || pc_fp !== '0 || pm_fp !== '0) begin
      bad++; $display("FAIL reset_perf gnt=%0d conf=%0d mh=%0d want=0", pg_fp, pc_fp, pm_fp); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_read_hit();
    set_array(8'h08);
    bus_fp.rtag[3] = 44'h5;
    bus_fp.rtag[5] = 44'h5;
    @(negedge clk); idle(); put(2, 8'hFF, 12'h040, 44'h5, 1'b0, '0, '0); #1;
    total++; if (bus_fp.gnt !== 5'b00100 || bus_rr.gnt !== 5'b00100) begin
      bad++; $display("FAIL t1_gnt fp=%b rr=%b want=00100", bus_fp.gnt, bus_rr.gnt); end
    total++; if (bus_fp.sram_addr !== 12'h040 || bus_fp.sram_req !== 8'hFF || bus_fp.sram_we !== 1'b0) begin
      bad++; $display("FAIL t1_sram addr=%h req=%h we=%b want=040/ff/0", bus_fp.sram_addr, bus_fp.sram_req, bus_fp.sram_we); end
    exp_gnt++;
    exp_q.push_back('{cyc + 1, 5'b00100, 8'h08, line_of(3), 1'b0});
    @(negedge clk); idle(); put(1, 8'h01, 12'h041, 44'h7, 1'b0, '0, '0); #1;
    total++; if (bus_fp.gnt !== 5'b00010 || bus_rr.gnt !== 5'b00010) begin
      bad++; $display("FAIL miss_gnt fp=%b rr=%b want=00010", bus_fp.gnt, bus_rr.gnt); end
    exp_gnt++;
    exp_q.push_back('{cyc + 1, 5'b00010, 8'h00, '0, 1'b0});
    @(negedge clk); idle(); put(3, 8'h10, 12'h042, 44'h5, 1'b0, '0, '0); #1;
    total++; if (bus_fp.gnt !== 5'b01000 || bus_rr.gnt !== 5'b01000 || bus_fp.sram_addr !== 12'h042) begin
      bad++; $display("FAIL b2b_gnt fp=%b rr=%b addr=%h want=01000/042", bus_fp.gnt, bus_rr.gnt, bus_fp.sram_addr); end
    exp_gnt++;
    exp_q.push_back('{cyc + 1, 5'b01000, 8'h08, line_of(3), 1'b0});
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  task automatic test_multi_hit();
    logic [31:0] mh0;
    mh0 = pm_fp;
    set_array(8'h81);
    bus_fp.rtag[0] = 44'h9;
    bus_fp.rtag[7] = 44'h9;
    @(negedge clk); idle(); put(4, 8'h81, 12'h080, 44'h9, 1'b0, '0, '0); #1;
    total++; if (bus_fp.gnt !== 5'b10000 || bus_rr.gnt !== 5'b10000) begin
      bad++; $display("FAIL t4_gnt fp=%b rr=%b want=10000", bus_fp.gnt, bus_rr.gnt); end
    exp_gnt++;
    exp_q.push_back('{cyc + 1, 5'b10000, 8'h01, line_of(0), 1'b1});
    @(negedge clk); idle();
    @(negedge clk); #3;
`ifdef DCACHE_ARB_PERF_EN
    total++; if (pm_fp !== mh0 + 32'd1 || pm_rr !== mh0 + 32'd1) begin
      bad++; $display("FAIL t4_perf_mh fp=%0d rr=%0d want=%0d", pm_fp, pm_rr, mh0 + 32'd1); end
`else
    total++; if (pm_fp !== 32'd0 || pm_rr !== 32'd0 || mh0 !== 32'd0) begin
      bad++; $display("FAIL t4_perf_mh fp=%0d rr=%0d want=0", pm_fp, pm_rr); end
`endif
  endtask

  task automatic test_idle();
    @(negedge clk); idle(); #1;
    total++; if (bus_fp.gnt !== '0 || bus_rr.gnt !== '0) begin
      bad++; $display("FAIL idle_gnt fp=%b rr=%b want=0", bus_fp.gnt, bus_rr.gnt); end
    total++; if (bus_fp.sram_req !== '0 || bus_fp.sram_addr !== '0 || bus_fp.sram_we !== 1'b0 ||
                 bus_fp.sram_wdata !== '0 || bus_fp.sram_be !== '0 || bus_rr.sram_req !== '0) begin
      bad++; $display("FAIL idle_sram req=%h addr=%h we=%b want=0", bus_fp.sram_req, bus_fp.sram_addr, bus_fp.sram_we); end
  endtask

  task automatic test_write_read();
    set_array(8'h08);
    bus_fp.rtag[3] = 44'h5;
    @(negedge clk); idle(); put(1, 8'h04, 12'h123, 44'h0, 1'b1, wd_pat, be_pat); #1;
    total++; if (bus_fp.gnt !== 5'b00010 || bus_rr.gnt !== 5'b00010 || bus_fp.sram_we !== 1'b1) begin
      bad++; $display("FAIL t5_wr_gnt fp=%b rr=%b we=%b want=00010/1", bus_fp.gnt, bus_rr.gnt, bus_fp.sram_we); end
    total++; if (bus_fp.sram_wdata !== wd_pat || bus_fp.sram_be !== be_pat || bus_fp.sram_req !== 8'h04 || bus_fp.sram_addr !== 12'h123) begin
      bad++; $display("FAIL t5_wr_data wdata=%h be=%h req=%h addr=%h", bus_fp.sram_wdata, bus_fp.sram_be, bus_fp.sram_req, bus_fp.sram_addr); end
    exp_gnt++;
    @(negedge clk); idle(); put(3, 8'h08, 12'h055, 44'h5, 1'b0, '0, '0); #1;
    total++; if (bus_fp.gnt !== 5'b01000 || bus_fp.sram_we !== 1'b0) begin
      bad++; $display("FAIL t5_rd_gnt gnt=%b we=%b want=01000/0", bus_fp.gnt, bus_fp.sram_we); end
    exp_gnt++;
    exp_q.push_back('{cyc + 1, 5'b01000, 8'h08, line_of(3), 1'b0});
    @(negedge clk); idle(); put(2, 8'h01, 12'h066, 44'h5, 1'b0, '0, '0); #1;
    total++; if (bus_fp.gnt !== 5'b00100) begin
      bad++; $display("FAIL t5_kill_gnt gnt=%b want=00100", bus_fp.gnt); end
    @(negedge clk); idle(); rst_n = 1'b0; exp_gnt = 0; #1;
    total++; if (bus_fp.rvalid !== '0 || bus_rr.rvalid !== '0 || bus_fp.gnt !== '0) begin
      bad++; $display("FAIL t5_reset_drop fp=%b rr=%b gnt=%b want=0", bus_fp.rvalid, bus_rr.rvalid, bus_fp.gnt); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] want_rr;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); idle();
      for (int p = 1; p <= 3; p++) put(p, 8'hF0, 12'(12'h100 + p), 44'h0, 1'b1, '0, '0);
      if (i == 6) put(0, 8'h01, 12'h100, 44'h0, 1'b1, '0, '0);
      #1;
      want_rr = (i == 6) ? 5'b00001 : (i == 7) ? 5'b00010 : (5'b00010 << (i % 3));
      total++; if (bus_rr.gnt !== want_rr) begin
        bad++; $display("FAIL t2_rr_gnt step=%0d got=%b want=%b", i, bus_rr.gnt, want_rr); end
      total++; if (bus_fp.gnt !== ((i == 6) ? 5'b00001 : 5'b00010)) begin
        bad++; $display("FAIL t2_fp_gnt step=%0d got=%b want=%b", i, bus_fp.gnt, (i == 6) ? 5'b00001 : 5'b00010); end
      exp_gnt++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_rr_wrap();
    logic [NP-1:0] msk [5] = '{5'b01000, 5'b10010, 5'b10010, 5'b01000, 5'b00010};
    logic [NP-1:0] wrr [5] = '{5'b01000, 5'b10000, 5'b00010, 5'b01000, 5'b00010};
    logic [NP-1:0] wfp [5] = '{5'b01000, 5'b00010, 5'b00010, 5'b01000, 5'b00010};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); idle();
      for (int p = 0; p < NP; p++) if (msk[i][p]) put(p, 8'h0F, 12'h200, 44'h0, 1'b1, '0, '0);
      #1;
      total++; if (bus_rr.gnt !== wrr[i] || bus_fp.gnt !== wfp[i]) begin
        bad++; $display("FAIL t6_wrap step=%0d rr=%b want=%b fp=%b want=%b", i, bus_rr.gnt, wrr[i], bus_fp.gnt, wfp[i]); end
      exp_gnt++;
    end
    @(negedge clk); idle();
  endtask

  task automatic test_starvation();
    logic [NP-1:0] want;
    set_array(8'h08);
    bus_fp.rtag[3] = 44'h5;
    // Port 3 drops its request after 10 waits; its count must restart from zero.
    for (int i = 0; i < 27; i++) begin
      @(negedge clk); idle();
      put(0, 8'h01, 12'h300, 44'h0, 1'b1, '0, '0);
      if (i != 10) put(3, 8'h02, 12'h303, 44'h0, 1'b1, '0, '0);
      #1;
      want = (i == 26) ? 5'b01000 : 5'b00001;
      total++; if (bus_fp.gnt !== want || bus_rr.gnt !== want) begin
        bad++; $display("FAIL t3_p3 step=%0d fp=%b rr=%b want=%b", i, bus_fp.gnt, bus_rr.gnt, want); end
      exp_gnt++;
    end
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); idle();
      put(0, 8'h01, 12'h300, 44'h0, 1'b1, '0, '0);
      if (i < 16) put(4, 8'h08, 12'h304, 44'h5, 1'b0, '0, '0);
      #1;
      want = (i == 15) ? 5'b10000 : 5'b00001;
      total++; if (bus_fp.gnt !== want || bus_rr.gnt !== want) begin
        bad++; $display("FAIL t3_p4 step=%0d fp=%b rr=%b want=%b", i, bus_fp.gnt, bus_rr.gnt, want); end
      if (i == 15) begin
        total++; if (bus_fp.sram_we !== 1'b0 || bus_fp.sram_addr !== 12'h304) begin
          bad++; $display("FAIL t3_sram we=%b addr=%h want=0/304", bus_fp.sram_we, bus_fp.sram_addr); end
        exp_q.push_back('{cyc + 1, 5'b10000, 8'h08, line_of(3), 1'b0});
      end
      exp_gnt++;
    end
    @(negedge clk); idle();
    @(negedge clk);
  endtask

  initial begin
    idle();
    set_array(8'h00);
    test_reset();
    test_read_hit();
    test_multi_hit();
    test_idle();
    test_write_read();
    test_round_robin();
    test_rr_wrap();
    test_starvation();
    @(negedge clk); #3;
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain left=%0d want=0", exp_q.size()); end
`ifdef DCACHE_ARB_PERF_EN
    total++; if (pg_fp !== 32'(exp_gnt) || pg_rr !== 32'(exp_gnt)) begin
      bad++; $display("FAIL perf_gnt fp=%0d rr=%0d want=%0d", pg_fp, pg_rr, exp_gnt); end
`else
    total++; if (pg_fp !== '0 || pc_fp !== '0 || pm_fp !== '0 || pg_rr !== '0 || pc_rr !== '0 || pm_rr !== '0) begin
      bad++; $display("FAIL perf_tied fp=%0d/%0d/%0d rr=%0d/%0d/%0d want=0", pg_fp, pc_fp, pm_fp, pg_rr, pc_rr, pm_rr); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit=20000", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
